// File: rtl/fft_peak_detect.sv
// ---------------------------------------------------------------------------
// fft_peak_detect
// Sink for the FFT master output stream. Each tlast-delimited frame carries
// the spectrum of one tone-correction frame. The block squares the magnitude
// of every bin (|X[k]|^2 = re^2 + im^2), tracks the largest one over bins
// 1..N_FFT/2-1 (DC and the mirrored upper half are ignored) and reports the
// peak bin and its magnitude once per frame.
//
// Ports
//   clk                in   system clock
//   rst_n              in   asynchronous reset, active-low
//   fft_m_data_tdata   in   beat: [DW-1:0] = re, [2*DW-1:DW] = im, signed
//   fft_m_data_tvalid  in   beat valid
//   fft_m_data_tlast   in   last beat of frame
//   fft_m_data_tready  out  block accepts a beat (high only while receiving)
//   peak_bin           out  bin of maximum magnitude, held until next report
//   peak_mag           out  |X|^2 of that bin (unsigned), held until next report
//   result_valid       out  one-cycle pulse, peak_bin/peak_mag just updated
//   frame_err          out  one-cycle pulse, framing violation, frame dropped
// ---------------------------------------------------------------------------
module fft_peak_detect #(
   parameter int N_FFT = 256,
   parameter int DW    = 16,
   parameter int IDX_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2*DW-1:0]   fft_m_data_tdata,
   input  logic              fft_m_data_tvalid,
   input  logic              fft_m_data_tlast,
   output logic              fft_m_data_tready,
   output logic [IDX_W-1:0]  peak_bin,
   output logic [2*DW-1:0]   peak_mag,
   output logic              result_valid,
   output logic              frame_err
);

   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N_FFT - 1);
   localparam logic [IDX_W-1:0] HALF_K = IDX_W'(N_FFT / 2 - 1);
   localparam logic [IDX_W-1:0] ONE_K  = IDX_W'(1);
   localparam logic [IDX_W-1:0] ZERO_K = IDX_W'(0);

   typedef enum logic [1:0] {
      RECV   = 2'd0,
      FLUSH1 = 2'd1,
      FLUSH2 = 2'd2,
      REPORT = 2'd3
   } state_t;

   state_t               state_q;
   logic                 tready_q;
   logic [IDX_W-1:0]     peak_bin_q;
   logic [2*DW-1:0]      peak_mag_q;
   logic                 result_valid_q;
   logic                 frame_err_q;

   logic [IDX_W-1:0]     cnt_q, cnt_d;

   logic                 s1_valid_q;
   logic [2*DW-1:0]      s1_re2_q, s1_im2_q;
   logic [IDX_W-1:0]     s1_k_q;
   logic                 s2_valid_q;
   logic [2*DW-1:0]      s2_mag_q;
   logic [IDX_W-1:0]     s2_k_q;

   logic [IDX_W-1:0]     best_bin_q, best_bin_d;
   logic [2*DW-1:0]      best_mag_q, best_mag_d;

   logic                 accept_s;
   logic                 at_last_k_s;
   logic                 good_end_s;
   logic                 frame_bad_s;
   logic signed [2*DW-1:0] re_ext_s, im_ext_s;
   logic [2*DW-1:0]      re_sq_s, im_sq_s;

   assign accept_s    = fft_m_data_tvalid & tready_q;
   assign at_last_k_s = (cnt_q == LAST_K);
   // Framing is judged only on accepted beats: tlast must coincide with the last bin.
   assign good_end_s  = accept_s & fft_m_data_tlast & at_last_k_s;
   assign frame_bad_s = accept_s & (fft_m_data_tlast ^ at_last_k_s);

   // Sign-extend both components so the square is computed at full 2*DW width.
   assign re_ext_s = {{DW{fft_m_data_tdata[DW-1]}}, fft_m_data_tdata[DW-1:0]};
   assign im_ext_s = {{DW{fft_m_data_tdata[2*DW-1]}}, fft_m_data_tdata[2*DW-1:DW]};
   assign re_sq_s  = re_ext_s * re_ext_s;
   assign im_sq_s  = im_ext_s * im_ext_s;

   assign fft_m_data_tready = tready_q;
   assign peak_bin          = peak_bin_q;
   assign peak_mag          = peak_mag_q;
   assign result_valid      = result_valid_q;
   assign frame_err         = frame_err_q;

   // Bin counter next state: restarts at 0 after a good frame end or a framing error.
   always_comb begin
      cnt_d = cnt_q;
      if (!accept_s) begin
         cnt_d = cnt_q;
      end else if (good_end_s || frame_bad_s) begin
         cnt_d = ZERO_K;
      end else begin
         cnt_d = cnt_q + ONE_K;
      end
   end

   // Running-maximum next state: bin 1 seeds the search, later bins win only when strictly larger.
   always_comb begin
      best_bin_d = best_bin_q;
      best_mag_d = best_mag_q;
      if (s2_valid_q && (s2_k_q >= ONE_K) && (s2_k_q <= HALF_K)) begin
         if ((s2_k_q == ONE_K) || (s2_mag_q > best_mag_q)) begin
            best_bin_d = s2_k_q;
            best_mag_d = s2_mag_q;
         end else begin
            best_bin_d = best_bin_q;
            best_mag_d = best_mag_q;
         end
      end else begin
         best_bin_d = best_bin_q;
         best_mag_d = best_mag_q;
      end
   end

   // Magnitude pipeline (square, sum, compare); a framing error flushes everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= ZERO_K;
         s1_valid_q <= 1'b0;
         s1_re2_q   <= '0;
         s1_im2_q   <= '0;
         s1_k_q     <= ZERO_K;
         s2_valid_q <= 1'b0;
         s2_mag_q   <= '0;
         s2_k_q     <= ZERO_K;
         best_bin_q <= ZERO_K;
         best_mag_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         s1_valid_q <= accept_s & ~frame_bad_s;
         if (accept_s) begin
            s1_re2_q <= re_sq_s;
            s1_im2_q <= im_sq_s;
            s1_k_q   <= cnt_q;
         end else begin
            s1_re2_q <= s1_re2_q;
            s1_im2_q <= s1_im2_q;
            s1_k_q   <= s1_k_q;
         end
         s2_valid_q <= s1_valid_q & ~frame_bad_s;
         s2_mag_q   <= s1_re2_q + s1_im2_q;
         s2_k_q     <= s1_k_q;
         if (frame_bad_s) begin
            best_bin_q <= ZERO_K;
            best_mag_q <= '0;
         end else begin
            best_bin_q <= best_bin_d;
            best_mag_q <= best_mag_d;
         end
      end
   end

   // Frame FSM with registered handshake and report outputs.
   // The last beat spends two cycles draining the pipeline (FLUSH1/FLUSH2); the
   // report is loaded from best_d so the final in-range compare is included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RECV;
         tready_q       <= 1'b0;
         peak_bin_q     <= ZERO_K;
         peak_mag_q     <= '0;
         result_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         frame_err_q    <= frame_bad_s;
         case (state_q)
            RECV: begin
               if (good_end_s) begin
                  state_q  <= FLUSH1;
                  tready_q <= 1'b0;
               end else begin
                  state_q  <= RECV;
                  tready_q <= 1'b1;
               end
            end
            FLUSH1: begin
               state_q  <= FLUSH2;
               tready_q <= 1'b0;
            end
            FLUSH2: begin
               state_q        <= REPORT;
               tready_q       <= 1'b0;
               peak_bin_q     <= best_bin_d;
               peak_mag_q     <= best_mag_d;
               result_valid_q <= 1'b1;
            end
            REPORT: begin
               state_q  <= RECV;
               tready_q <= 1'b1;
            end
            default: begin
               state_q  <= RECV;
               tready_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_peak_detect.sv
// ---------------------------------------------------------------------------
// tb_fft_peak_detect
// Self-checking bench for fft_peak_detect: a table of directed frames, random
// frames checked against a plain arithmetic peak model, and hand-written
// sequences for short/long frames and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_fft_peak_detect;

   localparam int N = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tlast;
   logic        tready;
   logic [7:0]  peak_bin;
   logic [31:0] peak_mag;
   logic        result_valid;
   logic        frame_err;

   int fr_re[N];
   int fr_im[N];

   int n_checks = 0;
   int n_pass   = 0;
   int rv_cnt   = 0;
   int err_cnt  = 0;

   always #5 clk = ~clk;

   fft_peak_detect #(.N_FFT(256), .DW(16), .IDX_W(8)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fft_m_data_tdata  (tdata),
      .fft_m_data_tvalid (tvalid),
      .fft_m_data_tlast  (tlast),
      .fft_m_data_tready (tready),
      .peak_bin          (peak_bin),
      .peak_mag          (peak_mag),
      .result_valid      (result_valid),
      .frame_err         (frame_err)
   );

   // pulse counters sampled away from the active edge
   always @(negedge clk) begin
      if (result_valid === 1'b1) rv_cnt <= rv_cnt + 1;
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic clear_frame();
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 0;
         fr_im[k] = 0;
      end
   endtask

   // reference: largest re^2+im^2 over bins 1..N/2-1, lowest bin wins ties
   task automatic model(output int bin, output longint mag);
      longint m;
      bin = 1;
      mag = longint'(fr_re[1]) * fr_re[1] + longint'(fr_im[1]) * fr_im[1];
      for (int k = 2; k < N / 2; k++) begin
         m = longint'(fr_re[k]) * fr_re[k] + longint'(fr_im[k]) * fr_im[k];
         if (m > mag) begin
            bin = k;
            mag = m;
         end
      end
   endtask

   // send n_beats beats from the frame arrays; tlast on beat last_pos (-1: never)
   task automatic send_frame(input int n_beats, input int last_pos, input bit gaps,
                             output int first_wait);
      logic signed [15:0] r16, i16;
      int guard;
      bit acc;
      first_wait = 0;
      for (int k = 0; k < n_beats; k++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            tvalid = 1'b0;
            tlast  = 1'b0;
            repeat ($urandom_range(1, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         r16    = 16'(fr_re[k]);
         i16    = 16'(fr_im[k]);
         tdata  = {i16, r16};
         tvalid = 1'b1;
         tlast  = (k == last_pos);
         acc    = 1'b0;
         guard  = 0;
         while (!acc && guard < 20) begin
            acc = tready;
            @(posedge clk);
            #1;
            guard++;
         end
         if (k == 0) first_wait = guard;
         if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout: got no tready, expected beat %0d accepted", k);
            break;
         end
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   // called right after the last beat's accepting edge
   task automatic finish_frame(input int exp_bin, input longint exp_mag, input string tag);
      int low = 0;
      int rv_at = 0;
      longint gb = -1;
      longint gm = -1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (result_valid) begin
            rv_at = n;
            gb = longint'(peak_bin);
            gm = longint'(peak_mag);
         end
         if (tready) break;
         low++;
      end
      check({tag, "_tready_low"}, low, 3);
      check({tag, "_rv_cycle"}, rv_at, 3);
      check({tag, "_bin"}, gb, exp_bin);
      check({tag, "_mag"}, gm, exp_mag);
   endtask

   typedef struct {
      int k0, re0, im0;
      int k1, re1, im1;
      int k2, re2, im2;
      int exp_bin;
      longint exp_mag;
      bit gaps;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int fw, mb, rv0, e0, last_bin;
      longint mm, last_mag;

      vecs[0] = '{10, 1000, 0,      -1, 0, 0,           -1, 0, 0,         10, 64'd1000000, 1'b0};
      vecs[1] = '{20, 0, 500,       40, 0, 500,         0, 30000, 0,      20, 64'd250000, 1'b0};
      vecs[2] = '{127, -32768, -32768, 200, -32768, -32768, 128, 32767, 32767, 127, 64'h80000000, 1'b0};
      vecs[3] = '{-1, 0, 0,         -1, 0, 0,           -1, 0, 0,         1, 64'd0, 1'b0};
      vecs[4] = '{1, 5, 0,          2, 0, 5,            255, 20000, 0,    1, 64'd25, 1'b0};
      vecs[5] = '{126, 3, 0,        127, 0, 3,          -1, 0, 0,         126, 64'd9, 1'b0};
      vecs[6] = '{64, 1200, 0,      63, 0, 1100,        65, -1100, 0,     64, 64'd1440000, 1'b1};
      vecs[7] = '{64, 1200, 0,      63, 0, 1100,        65, -1100, 0,     64, 64'd1440000, 1'b0};

      rst_n  = 1'b0;
      tvalid = 1'b0;
      tlast  = 1'b0;
      tdata  = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_tready", tready, 0);
      check("rst_bin", peak_bin, 0);
      check("rst_mag", peak_mag, 0);
      check("rst_rv", result_valid, 0);
      check("rst_err", frame_err, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel_tready", tready, 1);

      // directed table, frames back to back
      for (int i = 0; i < 8; i++) begin
         clear_frame();
         if (vecs[i].k0 >= 0) begin fr_re[vecs[i].k0] = vecs[i].re0; fr_im[vecs[i].k0] = vecs[i].im0; end
         if (vecs[i].k1 >= 0) begin fr_re[vecs[i].k1] = vecs[i].re1; fr_im[vecs[i].k1] = vecs[i].im1; end
         if (vecs[i].k2 >= 0) begin fr_re[vecs[i].k2] = vecs[i].re2; fr_im[vecs[i].k2] = vecs[i].im2; end
         send_frame(N, N - 1, vecs[i].gaps, fw);
         if (i > 0 && !vecs[i].gaps) check($sformatf("vec%0d_b2b_first", i), fw, 1);
         finish_frame(vecs[i].exp_bin, vecs[i].exp_mag, $sformatf("vec%0d", i));
      end

      // random frames against the model
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < N; k++) begin
            fr_re[k] = int'($urandom_range(0, 16000)) - 8000;
            fr_im[k] = int'($urandom_range(0, 16000)) - 8000;
         end
         model(mb, mm);
         send_frame(N, N - 1, r[0], fw);
         finish_frame(mb, mm, $sformatf("rand%0d", r));
         last_bin = mb;
         last_mag = mm;
      end

      // short frame: tlast at k=100
      rv0 = rv_cnt;
      e0  = err_cnt;
      clear_frame();
      fr_re[99] = 30000;
      send_frame(101, 100, 1'b0, fw);
      @(negedge clk);
      check("short_err_pulse", frame_err, 1);
      check("short_tready", tready, 1);
      check("short_hold_bin", peak_bin, last_bin);
      check("short_hold_mag", peak_mag, last_mag);
      @(negedge clk);
      check("short_err_end", frame_err, 0);
      repeat (5) @(negedge clk);
      check("short_no_rv", rv_cnt, rv0);
      check("short_err_cnt", err_cnt, e0 + 1);
      clear_frame();
      fr_re[5] = 700;
      send_frame(N, N - 1, 1'b0, fw);
      finish_frame(5, 490000, "after_short");

      // long frame: no tlast on k=255
      rv0 = rv_cnt;
      clear_frame();
      fr_im[50] = 900;
      send_frame(N, -1, 1'b0, fw);
      @(negedge clk);
      check("long_err_pulse", frame_err, 1);
      repeat (5) @(negedge clk);
      check("long_no_rv", rv_cnt, rv0);
      clear_frame();
      fr_im[7] = -300;
      send_frame(N, N - 1, 1'b0, fw);
      finish_frame(7, 90000, "after_long");

      // reset in the middle of a frame at k=80
      clear_frame();
      fr_re[80] = 9000;
      send_frame(81, -1, 1'b0, fw);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_tready", tready, 0);
      check("mid_rst_bin", peak_bin, 0);
      check("mid_rst_mag", peak_mag, 0);
      check("mid_rst_rv", result_valid, 0);
      repeat (2) @(negedge clk);
      rv0 = rv_cnt;
      rst_n = 1'b1;
      clear_frame();
      fr_re[3] = -2000;
      send_frame(N, N - 1, 1'b0, fw);
      finish_frame(3, 4000000, "after_rst");
      repeat (3) @(negedge clk);
      check("after_rst_rv_count", rv_cnt, rv0 + 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
